// File: rtl/memory_access_pkg.sv
// memory_access_pkg: shared types and constants for the memory stage.
//   - Datapath widths (XLEN, PC_WIDTH, LOAD_WIDTH, STORE_WIDTH)
//   - Bubble values NOP_PC / NOP_COMMIT
//   - Load/store opcode encodings (0 = no access)
//   - FSM state type and the memory/writeback register bundle
package memory_access_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned PC_WIDTH    = 32;
  localparam int unsigned LOAD_WIDTH  = 3;
  localparam int unsigned STORE_WIDTH = 2;

  localparam logic [PC_WIDTH-1:0] NOP_PC     = '0;
  localparam logic                NOP_COMMIT = 1'b0;

  typedef enum logic [LOAD_WIDTH-1:0] {
    LD_NONE = 3'd0,
    LD_LB   = 3'd1,
    LD_LH   = 3'd2,
    LD_LW   = 3'd3,
    LD_LBU  = 3'd4,
    LD_LHU  = 3'd5
  } load_op_e;

  typedef enum logic [STORE_WIDTH-1:0] {
    ST_NONE = 2'd0,
    ST_SB   = 2'd1,
    ST_SH   = 2'd2,
    ST_SW   = 2'd3
  } store_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0]     valw;
    logic                need_dste;
    logic [4:0]          dste;
    logic [PC_WIDTH-1:0] pc;
    logic                commit;
    logic                excp;
  } mw_t;

  localparam mw_t MW_BUBBLE = '{
    valw:      '0,
    need_dste: 1'b0,
    dste:      '0,
    pc:        NOP_PC,
    commit:    NOP_COMMIT,
    excp:      1'b0
  };

endpackage

// File: rtl/memory_access_if.sv
// memory_access_if: data-memory request/acknowledge bus.
//   dmem_req_o   request, held until acknowledged
//   dmem_we_o    write strobe
//   dmem_addr_o  word-aligned address
//   dmem_wdata_o write data
//   dmem_be_o    byte enables
//   dmem_ack_i   acknowledge
//   dmem_rdata_i read data, valid with dmem_ack_i
// Signal names keep their original port names; the suffix is relative to
// the memory stage (master).
interface memory_access_if;
  import memory_access_pkg::*;

  logic            dmem_req_o;
  logic            dmem_we_o;
  logic [XLEN-1:0] dmem_addr_o;
  logic [XLEN-1:0] dmem_wdata_o;
  logic [3:0]      dmem_be_o;
  logic            dmem_ack_i;
  logic [XLEN-1:0] dmem_rdata_i;

  modport master (
    output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o,
    input  dmem_ack_i, dmem_rdata_i
  );

  modport slave (
    input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o,
    output dmem_ack_i, dmem_rdata_i
  );

endinterface

// File: rtl/memory_access_mem_align.sv
// mem_align: combinational byte-lane logic for the memory stage.
//   load_op_i/store_op_i/addr_lo_i/store_data_i : request side, from the
//     execute register; produce wdata_o, be_o and misalign_o.
//   rd_op_i/rd_off_i/rdata_i : response side, from the latched request;
//     produce load_data_o (aligned and sign/zero extended).
module mem_align
  import memory_access_pkg::*;
(
  input  logic [LOAD_WIDTH-1:0]  load_op_i,
  input  logic [STORE_WIDTH-1:0] store_op_i,
  input  logic [1:0]             addr_lo_i,
  input  logic [XLEN-1:0]        store_data_i,
  output logic [XLEN-1:0]        wdata_o,
  output logic [3:0]             be_o,
  output logic                   misalign_o,
  input  logic [LOAD_WIDTH-1:0]  rd_op_i,
  input  logic [1:0]             rd_off_i,
  input  logic [XLEN-1:0]        rdata_i,
  output logic [XLEN-1:0]        load_data_o
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    wdata_o = '0;
    be_o    = '0;
    case (store_op_i)
      ST_SB: begin
        wdata_o = {4{store_data_i[7:0]}};
        be_o    = 4'b0001 << addr_lo_i;
      end
      ST_SH: begin
        wdata_o = {2{store_data_i[15:0]}};
        be_o    = 4'b0011 << addr_lo_i;
      end
      ST_SW: begin
        wdata_o = store_data_i;
        be_o    = '1;
      end
      default: ;
    endcase
  end

  always_comb begin
    misalign_o = 1'b0;
    case (load_op_i)
      LD_LH, LD_LHU: misalign_o = addr_lo_i[0];
      LD_LW:         misalign_o = |addr_lo_i;
      default: ;
    endcase
    case (store_op_i)
      ST_SH:   misalign_o = misalign_o | addr_lo_i[0];
      ST_SW:   misalign_o = misalign_o | (|addr_lo_i);
      default: ;
    endcase
  end

  always_comb begin
    rd_byte = rdata_i[7:0];
    case (rd_off_i)
      2'd1:    rd_byte = rdata_i[15:8];
      2'd2:    rd_byte = rdata_i[23:16];
      2'd3:    rd_byte = rdata_i[31:24];
      default: rd_byte = rdata_i[7:0];
    endcase
    // halfwords only reach here aligned, so bit 1 picks the lane
    rd_half = rd_off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    load_data_o = rdata_i;
    case (rd_op_i)
      LD_LB:   load_data_o = {{24{rd_byte[7]}}, rd_byte};
      LD_LBU:  load_data_o = {24'd0, rd_byte};
      LD_LH:   load_data_o = {{16{rd_half[15]}}, rd_half};
      LD_LHU:  load_data_o = {16'd0, rd_half};
      default: load_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// memory_access: memory stage between the execute register and the
// memory/writeback register.
//   clk_i, rst_n        clock, asynchronous active-low reset
//   ED_*                execute-register outputs (held while M_stall_o)
//   dmem                data-memory bus (memory_access_if.master)
//   M_stall_o           stall request to the hazard unit (combinational)
//   MW_*                registered memory/writeback outputs
// Optional: `MEM_TIMEOUT_EN adds a bus watchdog of TIMEOUT_CYCLES cycles.
module memory_access
  import memory_access_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
)(
  input  logic                   clk_i,
  input  logic                   rst_n,
  input  logic [LOAD_WIDTH-1:0]  ED_load_op_i,
  input  logic [STORE_WIDTH-1:0] ED_store_op_i,
  input  logic [XLEN-1:0]        ED_valE_i,
  input  logic [XLEN-1:0]        ED_rs2_data_i,
  input  logic                   ED_sel_reg_i,
  input  logic                   ED_need_dstE_i,
  input  logic [4:0]             ED_dstE_i,
  input  logic [PC_WIDTH-1:0]    ED_PC_i,
  input  logic                   ED_commit_i,
  memory_access_if.master        dmem,
  output logic                   M_stall_o,
  output logic [XLEN-1:0]        MW_valW_o,
  output logic                   MW_need_dstE_o,
  output logic [4:0]             MW_dstE_o,
  output logic [PC_WIDTH-1:0]    MW_PC_o,
  output logic                   MW_commit_o,
  output logic                   MW_excp_o
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("memory_access: TIMEOUT_CYCLES must be in 1..255");
  end

  state_e                 state_q, state_d;
  logic [XLEN-1:0]        addr_q, addr_d;
  logic [XLEN-1:0]        wdata_q, wdata_d;
  logic [3:0]             be_q, be_d;
  logic                   we_q, we_d;
  logic [LOAD_WIDTH-1:0]  ld_op_q, ld_op_d;
  logic [1:0]             off_q, off_d;
  mw_t                    mw_q, mw_d;

  logic [XLEN-1:0]        fmt_wdata;
  logic [3:0]             fmt_be;
  logic                   misalign;
  logic [XLEN-1:0]        load_data;
  logic                   mem_op;
  logic                   timeout_hit;
  logic                   stall;

  mem_align u_mem_align (
    .load_op_i    (ED_load_op_i),
    .store_op_i   (ED_store_op_i),
    .addr_lo_i    (ED_valE_i[1:0]),
    .store_data_i (ED_rs2_data_i),
    .wdata_o      (fmt_wdata),
    .be_o         (fmt_be),
    .misalign_o   (misalign),
    .rd_op_i      (ld_op_q),
    .rd_off_i     (off_q),
    .rdata_i      (dmem.dmem_rdata_i),
    .load_data_o  (load_data)
  );

  assign mem_op = ED_commit_i && ((ED_load_op_i != '0) || (ED_store_op_i != '0));

`ifdef MEM_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;

  assign timeout_hit = (state_q == S_REQ) && !dmem.dmem_ack_i
                       && (cnt_q == 8'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    we_d    = we_q;
    ld_op_d = ld_op_q;
    off_d   = off_q;
    mw_d    = MW_BUBBLE;
    stall   = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (!mem_op) begin
          mw_d = '{valw: ED_valE_i, need_dste: ED_need_dstE_i, dste: ED_dstE_i,
                   pc: ED_PC_i, commit: ED_commit_i, excp: 1'b0};
        end else if (misalign) begin
          mw_d = '{valw: ED_valE_i, need_dste: 1'b0, dste: ED_dstE_i,
                   pc: ED_PC_i, commit: 1'b1, excp: 1'b1};
        end else begin
          state_d = S_REQ;
          addr_d  = {ED_valE_i[XLEN-1:2], 2'b00};
          wdata_d = fmt_wdata;
          be_d    = fmt_be;
          we_d    = (ED_store_op_i != '0);
          ld_op_d = ED_load_op_i;
          off_d   = ED_valE_i[1:0];
          stall   = 1'b1;
`ifdef MEM_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end

      S_REQ: begin
        if (dmem.dmem_ack_i) begin
          state_d = S_IDLE;
          mw_d = '{valw: ED_sel_reg_i ? load_data : ED_valE_i,
                   need_dste: ED_need_dstE_i, dste: ED_dstE_i,
                   pc: ED_PC_i, commit: ED_commit_i, excp: 1'b0};
        end else if (timeout_hit) begin
          // Stall is released here so the timed-out op retires instead of
          // being re-issued from IDLE with the same held ED inputs.
          state_d = S_IDLE;
          mw_d = '{valw: ED_valE_i, need_dste: 1'b0, dste: ED_dstE_i,
                   pc: ED_PC_i, commit: 1'b1, excp: 1'b1};
        end else begin
          stall = 1'b1;
`ifdef MEM_TIMEOUT_EN
          cnt_d = cnt_q + 8'd1;
`endif
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      ld_op_q <= '0;
      off_q   <= '0;
      mw_q    <= MW_BUBBLE;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
      ld_op_q <= ld_op_d;
      off_q   <= off_d;
      mw_q    <= mw_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign dmem.dmem_req_o   = (state_q == S_REQ);
  assign dmem.dmem_we_o    = we_q;
  assign dmem.dmem_addr_o  = addr_q;
  assign dmem.dmem_wdata_o = wdata_q;
  assign dmem.dmem_be_o    = be_q;

  assign M_stall_o      = stall;
  assign MW_valW_o      = mw_q.valw;
  assign MW_need_dstE_o = mw_q.need_dste;
  assign MW_dstE_o      = mw_q.dste;
  assign MW_PC_o        = mw_q.pc;
  assign MW_commit_o    = mw_q.commit;
  assign MW_excp_o      = mw_q.excp;

endmodule
